pcpi_result_nibble_tx: RTL

Return-path serializer for the PCPI coprocessor wrapper. It captures the 32-bit result word the coprocessor presents on `pcpi_rd` when `pcpi_ready` and `pcpi_wr` are both high. It then streams that word to the off-chip host as 4-bit nibbles, least-significant nibble first, using a valid/ack handshake. This is the transmit counterpart of the nibble instruction loader, which brings `pcpi_insn` in over the same 4-bit pin group.

---
 rtl/pcpi_result_nibble_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pcpi_result_nibble_tx.sv
// rtl/pcpi_result_nibble_tx.sv - PCPI result word to 4-bit host nibble stream, LS nibble first.
// Optional trailing XOR checksum nibble under `NIBBLE_TX_CHECKSUM_EN.
module pcpi_result_nibble_tx #(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcpi_ready,
  input  logic                 pcpi_wr,
  input  logic [4*NIBBLES-1:0] pcpi_rd,
  input  logic                 host_ack,
  input  logic                 clear_ovf,
  output logic [3:0]           tx_nibble,
  output logic                 tx_valid,
  output logic                 tx_last,
  output logic                 busy,
  output logic                 overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

`ifdef NIBBLE_TX_CHECKSUM_EN
  // The checksum rides in the top nibble of the shifter, so it falls out after the data.
  localparam int SW       = W + 4;
  localparam int LAST_CNT = NIBBLES;
`else
  localparam int SW       = W;
  localparam int LAST_CNT = NIBBLES - 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t          state;
  logic [SW-1:0]   shift;
  logic [CW-1:0]   count;

  logic            capture;
  logic            accept;
  logic            at_last;
  logic            ovf_set;
  logic [SW-1:0]   load_word;

`ifdef NIBBLE_TX_CHECKSUM_EN
  function automatic logic [3:0] nib_xor(input logic [W-1:0] w);
    logic [3:0] x;
    x = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      x = x ^ w[4*i +: 4];
    end
    return x;
  endfunction

  assign load_word = {nib_xor(pcpi_rd), pcpi_rd};
`else
  assign load_word = pcpi_rd;
`endif

  assign capture = pcpi_ready & pcpi_wr;
  assign at_last = (count == CW'(LAST_CNT));
  assign accept  = (state == SEND) & host_ack;
  // A capture that coincides with the final accept chains into the next word.
  assign ovf_set = capture & busy & ~(accept & at_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      count     <= '0;
      tx_nibble <= '0;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            shift     <= load_word;
            count     <= '0;
            state     <= SEND;
            tx_nibble <= pcpi_rd[3:0];
            tx_valid  <= 1'b1;
            tx_last   <= (LAST_CNT == 0);
            busy      <= 1'b1;
          end
        end

        SEND: begin
          if (host_ack) begin
            tx_nibble <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            if (!at_last) begin
              shift <= shift >> 4;
              count <= count + CW'(1);
              state <= GAP;
            end else if (capture) begin
              shift <= load_word;
              count <= '0;
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        GAP: begin
          state     <= SEND;
          tx_nibble <= shift[3:0];
          tx_valid  <= 1'b1;
          tx_last   <= at_last;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
